ysyx_22050019_mem_arbiter: RTL

- Two-master, one-slave arbiter for the core's single memory port.
- Master 0 is the instruction fetch path (read-only). Master 1 is the load/store path, driven by the decoder's ram_re/ram_we and width controls after the EXU.
- Handles one outstanding transaction at a time.
- Registers the winning request, issues it downstream with a valid/ready handshake, waits for the response, then routes it back to the owner.

---
 rtl/ysyx_22050019_mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22050019_mem_arbiter.sv
// Two-master, one-slave arbiter for the core's single memory port.
// Master 0 is instruction fetch (read-only), master 1 is load/store.
// Only one transaction is outstanding at a time: grant -> REQ -> RESP.
// Optional macro YSYX_22050019_ARB_RR_EN: simultaneous requests in IDLE
// go to the master that did not own the previous transaction; when the
// macro is undefined, load/store always wins a tie.
module ysyx_22050019_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_valid,
    input  logic                ls_wen,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_ready,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic                grantLs;
    logic                grantIf;
    logic                respFire;

    // Decide which master would win if the arbiter is idle this cycle.
    always_comb begin
`ifdef YSYX_22050019_ARB_RR_EN
        grantLs = ls_valid && (!if_valid || !owner_q);
`else
        grantLs = ls_valid;
`endif
        grantIf = if_valid && !grantLs;
    end

    // Next-state logic: capture the winner in IDLE, hold until accepted, then await the response.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            IDLE: begin
                if (grantLs) begin
                    owner_d = 1'b1;
                    wen_d   = ls_wen;
                    addr_d  = ls_addr;
                    wdata_d = ls_wdata;
                    wmask_d = ls_wmask;
                    state_d = REQ;
                end else if (grantIf) begin
                    owner_d = 1'b0;
                    wen_d   = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // A response only counts while waiting for one; stray mem_rvalid is dropped.
    assign respFire  = (state_q == RESP) && mem_rvalid;

    assign if_ready  = (state_q == IDLE) && grantIf;
    assign ls_ready  = (state_q == IDLE) && grantLs;

    assign mem_valid = (state_q == REQ);
    assign mem_wen   = wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    assign if_rvalid = respFire && !owner_q;
    assign ls_rvalid = respFire && owner_q;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule
